iot_event_arbiter: RTL and testbench
====================================

# iot_event_arbiter

Upstream stage of the active-IoT-devices monitor. Watches one activity level per device, turns each device connect/disconnect edge into a pending event, and serialises the events round-robin into the monitor's single-event interface: a one-cycle `on_off` strobe with `change` = 1 for join and 0 for leave. It also keeps a committed per-device map that always matches what the downstream 8-bit counter has been told.

## Interface
- `N_DEV`, 8, number of monitored devices; range 2..255, so the downstream 8-bit count cannot overflow.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `dev_on`  in  N_DEV  per-device activity level; bit i = 1 means device i connected. Synchronous to `clk`.
- `on_off`  out  1  event strobe to the monitor, high for exactly one cycle per emitted event.
- `change`  out  1  direction of the current event: 1 = increment (join), 0 = decrement (leave). Valid when `on_off`=1; holds its last value otherwise.
- `active_map`  out  N_DEV  committed connection state per device (events already emitted).
- `busy`  out  1  high when any event is pending.

## Operation
- Registers:
  - `dev_q[N_DEV]`: sampled copy of `dev_on`.
  - `pend[N_DEV]` and `pdir[N_DEV]`: pending flag and pending direction per device.
  - `rr`: round-robin pointer, ceil(log2 N_DEV) bits.
  - `active_map`, `on_off`, `change`.
- Edge detect, evaluated at each clock edge for every device i:
  - `e_i = dev_on[i] ^ dev_q[i]`; `dev_q[i] <= dev_on[i]`.
  - A rising level is a join (dir=1). A falling level is a leave (dir=0).
- Pending update for device i, applied in this priority order:
  1. Granted this edge and `e_i`=1: pend stays 1; `pdir` takes the new edge's direction.
  2. Granted this edge and `e_i`=0: pend cleared.
  3. Not granted, pend=1, and `e_i`=1: pend cleared. Join then leave, or leave then join, cancels with no net change.
  4. Not granted, pend=0, and `e_i`=1: pend set; `pdir` set to the edge direction.
- Grant: at each edge, select the first i with pend=1, scanning `rr`, `rr`+1, …, wrapping at N_DEV. Only pend values from before this edge count. At most one grant per edge. If there is a grant:
  - `on_off` <= 1; `change` <= `pdir[i]`; `active_map[i]` <= `pdir[i]`.
  - `rr` <= (i+1) mod N_DEV.
- With no grant, `on_off` <= 0 and `change` holds.
- Invariant: popcount(`active_map`) equals the downstream counter value one cycle after the last strobe. `active_map[i]` ^ `pend[i]` equals `dev_q[i]` at all times.
- `busy` = OR of `pend`, combinational from registers.

## Timing
- Reset, when `rst`=1 at an edge, regardless of other inputs:
  - `dev_q`, `pend`, `pdir`, `active_map`, `rr`, `on_off`, `change` all go to 0. `busy` reads 0.
  - No grant occurs on a reset edge.
- Reset mid-operation drops all pending events, with no strobe. Devices still high after reset produce join events on the first non-reset edge. This matches the monitor clearing to 0 on the same reset.
- Latency for a lone event:
  - `dev_on[i]` changes before edge k; pend set at edge k.
  - Grant at edge k+1, so `on_off`=1 during cycle k+1..k+2.
  - Monitor count updates at edge k+2.
- Worst-case latency for one device: N_DEV grant edges after its pend is set.
- Throughput: one event per cycle. Back-to-back strobes are allowed; `on_off` stays high across consecutive grant cycles.
- A level toggling every cycle on one device yields no net events while ungranted. Each toggle alternately sets and cancels pend.

## Test plan
- **Reset:** hold `rst`=1 with `dev_on`=8'hFF for 3 cycles. Required: `on_off`=0, `active_map`=0, `busy`=0 throughout. Release `rst`. Required: exactly 8 join strobes (`change`=1) on 8 consecutive cycles, in order device 0..7, ending with `active_map`=8'hFF.
- **Single join/leave:** from idle, raise `dev_on[3]`. Required: `on_off` high for exactly one cycle, 2 edges later, with `change`=1 and `active_map`=8'h08. Lower `dev_on[3]`. Required: one strobe with `change`=0 and `active_map`=8'h00.
- **Round robin:**
  - With `rr`=5, raise bits 2, 5 and 7 in the same cycle. Required grant order 5, 7, 2, after which `rr`=3.
- **Cancellation:**
  - With device 0 pending but blocked behind pend on devices 1..7 and `rr`=1, pulse `dev_on[0]` high for 1 cycle. Required: no event for device 0 and `active_map[0]`=0.
- **Re-arm on grant edge:** lower `dev_on[4]` on the same edge its join is granted. Required: join strobe, then a leave strobe on a later cycle, with `active_map[4]` returning to 0.
- **Reset mid-burst:** assert `rst` with 4 events pending. Required: strobes stop on that edge and `busy`=0. After release, re-joins occur only for the bits still high.

Source files
------------

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: turns per-device connect/disconnect edges into pending
// events and serialises them round-robin as one-cycle join/leave strobes,
// while keeping a committed map of what the downstream counter has seen.
module iot_event_arbiter #(
  parameter int unsigned N_DEV = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_DEV-1:0] i_dev_on,
  output logic             o_on_off,
  output logic             o_change,
  output logic [N_DEV-1:0] o_active_map,
  output logic             o_busy
);

  localparam int unsigned RR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  logic [N_DEV-1:0] r_dev_q;
  logic [N_DEV-1:0] r_pend;
  logic [N_DEV-1:0] r_pdir;
  logic [N_DEV-1:0] r_active_map;
  logic [RR_W-1:0]  r_rr;
  logic             r_on_off;
  logic             r_change;

  logic [N_DEV-1:0] w_edge;
  logic             w_grant_valid;
  logic [RR_W-1:0]  w_grant_idx;
  logic [RR_W-1:0]  w_rr_next;
  logic [RR_W:0]    w_scan_sum;
  logic [RR_W-1:0]  w_scan_idx;

  assign w_edge = i_dev_on ^ r_dev_q;

  // Round-robin pick: first pending device at or after r_rr, wrapping at N_DEV.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_scan_sum    = '0;
    w_scan_idx    = '0;
    for (int k = 0; k < N_DEV; k++) begin
      w_scan_sum = {1'b0, r_rr} + (RR_W+1)'(k);
      if (w_scan_sum >= (RR_W+1)'(N_DEV)) begin
        w_scan_sum = w_scan_sum - (RR_W+1)'(N_DEV);
      end
      w_scan_idx = RR_W'(w_scan_sum);
      if (!w_grant_valid && r_pend[w_scan_idx]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_scan_idx;
      end
    end
  end

  // Pointer advances past the granted device, wrapping to 0.
  always_comb begin
    if (w_grant_idx == RR_W'(N_DEV - 1)) begin
      w_rr_next = '0;
    end else begin
      w_rr_next = w_grant_idx + RR_W'(1);
    end
  end

  // Edge sampling, pending bookkeeping, grant and committed-map update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dev_q      <= '0;
      r_pend       <= '0;
      r_pdir       <= '0;
      r_active_map <= '0;
      r_rr         <= '0;
      r_on_off     <= 1'b0;
      r_change     <= 1'b0;
    end else begin
      r_dev_q <= i_dev_on;

      for (int i = 0; i < N_DEV; i++) begin
        if (w_grant_valid && (w_grant_idx == RR_W'(i))) begin
          // A fresh edge on the grant edge re-arms with the new direction.
          r_pend[i] <= w_edge[i];
          if (w_edge[i]) begin
            r_pdir[i] <= i_dev_on[i];
          end
        end else if (w_edge[i]) begin
          // Opposite edge while still pending cancels with no net change.
          if (r_pend[i]) begin
            r_pend[i] <= 1'b0;
          end else begin
            r_pend[i] <= 1'b1;
            r_pdir[i] <= i_dev_on[i];
          end
        end
      end

      if (w_grant_valid) begin
        r_on_off                  <= 1'b1;
        r_change                  <= r_pdir[w_grant_idx];
        r_active_map[w_grant_idx] <= r_pdir[w_grant_idx];
        r_rr                      <= w_rr_next;
      end else begin
        r_on_off <= 1'b0;
      end
    end
  end

  assign o_on_off     = r_on_off;
  assign o_change     = r_change;
  assign o_active_map = r_active_map;
  assign o_busy       = |r_pend;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Bench for iot_event_arbiter: directed scenarios plus randomized traffic
// checked against an event-level reference model.
`timescale 1ns/1ps
module tb_iot_event_arbiter;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] dev_on;
  logic         on_off;
  logic         change;
  logic [N-1:0] active_map;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  iot_event_arbiter #(.N_DEV(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_dev_on    (dev_on),
    .o_on_off    (on_off),
    .o_change    (change),
    .o_active_map(active_map),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-device arrays updated from the rules at each edge.
  bit       m_q    [N];
  bit       m_pend [N];
  bit       m_pdir [N];
  bit       m_map  [N];
  int       m_rr;
  bit       m_on_off;
  bit       m_change;

  always @(posedge clk) begin
    int  g;
    int  j;
    bit  e;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_q[i] = 0; m_pend[i] = 0; m_pdir[i] = 0; m_map[i] = 0;
      end
      m_rr = 0; m_on_off = 0; m_change = 0;
    end else begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
      if (g >= 0) begin
        m_on_off = 1;
        m_change = m_pdir[g];
        m_map[g] = m_pdir[g];
        m_rr     = (g + 1) % N;
      end else begin
        m_on_off = 0;
      end
      for (int i = 0; i < N; i++) begin
        e = (dev_on[i] != m_q[i]);
        if (i == g) begin
          m_pend[i] = e;
          if (e) m_pdir[i] = dev_on[i];
        end else if (e) begin
          if (m_pend[i]) m_pend[i] = 0;
          else begin m_pend[i] = 1; m_pdir[i] = dev_on[i]; end
        end
        m_q[i] = dev_on[i];
      end
    end
  end

  function automatic logic [N+2:0] model_view();
    logic [N-1:0] mp;
    bit           b;
    b = 0;
    for (int i = 0; i < N; i++) begin
      mp[i] = m_map[i];
      b     = b | m_pend[i];
    end
    return {m_on_off, m_change, mp, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] lvl);
    rst = 1'b1; dev_on = lvl;
    tick();
    rst = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    int exp_map;
    rst = 1'b1; dev_on = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (on_off !== 1'b0 || active_map !== 8'h00 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: on_off=%b map=%h busy=%b, want 0/00/0", on_off, active_map, busy);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_pend: on_off=%b busy=%b, want 0/1", on_off, busy);
    end
    for (int j = 0; j < N; j++) begin
      tick();
      exp_map = (1 << (j + 1)) - 1;
      n_checks++;
      if (on_off !== 1'b1 || change !== 1'b1 || active_map !== 8'(exp_map)) begin
        n_fail++;
        $display("FAIL reset_rejoin_%0d: on_off=%b change=%b map=%h, want 1/1/%h",
                 j, on_off, change, active_map, 8'(exp_map));
      end
    end
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b0 || active_map !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_rejoin_end: on_off=%b busy=%b map=%h, want 0/0/ff", on_off, busy, active_map);
    end
  endtask

  task automatic test_single_join_leave();
    do_reset(8'h00);
    dev_on = 8'h08;
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_join_pend: on_off=%b busy=%b, want 0/1", on_off, busy);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b1 || change !== 1'b1 || active_map !== 8'h08) begin
      n_fail++;
      $display("FAIL single_join_strobe: on_off=%b change=%b map=%h, want 1/1/08", on_off, change, active_map);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b0 || change !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_join_after: on_off=%b change=%b busy=%b, want 0/1/0", on_off, change, busy);
    end
    dev_on = 8'h00;
    tick();
    tick();
    n_checks++;
    if (on_off !== 1'b1 || change !== 1'b0 || active_map !== 8'h00) begin
      n_fail++;
      $display("FAIL single_leave_strobe: on_off=%b change=%b map=%h, want 1/0/00", on_off, change, active_map);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_leave_after: on_off=%b busy=%b, want 0/0", on_off, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5];
    exp_seq = '{8'h30, 8'hB0, 8'hB4, 8'hBC, 8'hBE};
    do_reset(8'h00);
    dev_on = 8'h10;
    tick(); tick(); tick();
    dev_on = 8'hB4;
    tick();
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (on_off !== 1'b1 || change !== 1'b1 || active_map !== exp_seq[s]) begin
        n_fail++;
        $display("FAIL rr_order_%0d: on_off=%b change=%b map=%h, want 1/1/%h",
                 s, on_off, change, active_map, exp_seq[s]);
      end
    end
    dev_on = 8'hBE;
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_gap: on_off=%b busy=%b, want 0/1", on_off, busy);
    end
    for (int s = 3; s < 5; s++) begin
      tick();
      n_checks++;
      if (on_off !== 1'b1 || active_map !== exp_seq[s]) begin
        n_fail++;
        $display("FAIL rr_ptr_%0d: on_off=%b map=%h, want 1/%h", s, on_off, active_map, exp_seq[s]);
      end
    end
  endtask

  task automatic test_cancellation();
    int strobes;
    do_reset(8'h00);
    dev_on = 8'h01; tick(); tick();
    dev_on = 8'h00; tick(); tick(); tick();
    dev_on = 8'hFE;
    tick();
    dev_on = 8'hFF;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) dev_on = 8'hFE;
      if (on_off === 1'b1) strobes++;
      n_checks++;
      if (active_map[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL cancel_map0_%0d: map=%h, want bit0=0", c, active_map);
      end
    end
    n_checks++;
    if (strobes != 7 || active_map !== 8'hFE || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_result: strobes=%0d map=%h busy=%b, want 7/fe/0", strobes, active_map, busy);
    end
  endtask

  task automatic test_rearm_on_grant();
    do_reset(8'h00);
    dev_on = 8'h10;
    tick();
    dev_on = 8'h00;
    tick();
    n_checks++;
    if (on_off !== 1'b1 || change !== 1'b1 || active_map !== 8'h10 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rearm_join: on_off=%b change=%b map=%h busy=%b, want 1/1/10/1",
               on_off, change, active_map, busy);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b1 || change !== 1'b0 || active_map !== 8'h00) begin
      n_fail++;
      $display("FAIL rearm_leave: on_off=%b change=%b map=%h, want 1/0/00", on_off, change, active_map);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rearm_idle: on_off=%b busy=%b, want 0/0", on_off, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset(8'h00);
    dev_on = 8'h1F;
    tick();
    tick();
    n_checks++;
    if (on_off !== 1'b1 || active_map !== 8'h01 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_burst: on_off=%b map=%h busy=%b, want 1/01/1", on_off, active_map, busy);
    end
    rst = 1'b1; dev_on = 8'h05;
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b0 || active_map !== 8'h00 || change !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cut: on_off=%b busy=%b map=%h change=%b, want 0/0/00/0",
               on_off, busy, active_map, change);
    end
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (on_off !== 1'b1 || change !== 1'b1 || active_map !== 8'h01) begin
      n_fail++;
      $display("FAIL midrst_rejoin0: on_off=%b change=%b map=%h, want 1/1/01", on_off, change, active_map);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b1 || active_map !== 8'h05) begin
      n_fail++;
      $display("FAIL midrst_rejoin2: on_off=%b map=%h, want 1/05", on_off, active_map);
    end
    tick();
    n_checks++;
    if (on_off !== 1'b0 || busy !== 1'b0 || active_map !== 8'h05) begin
      n_fail++;
      $display("FAIL midrst_end: on_off=%b busy=%b map=%h, want 0/0/05", on_off, busy, active_map);
    end
  endtask

  task automatic test_random_traffic();
    logic [N+2:0] got;
    logic [N+2:0] exp;
    int           r;
    int           hot;
    do_reset(8'h00);
    hot = $urandom_range(0, N - 1);
    for (int c = 0; c < 3000; c++) begin
      r   = $urandom_range(0, 11);
      rst = ($urandom_range(0, 199) == 0);
      if (r <= 3)      dev_on[$urandom_range(0, N - 1)] ^= 1'b1;
      else if (r == 4) dev_on = dev_on ^ 8'($urandom);
      else if (r == 5) dev_on[hot] ^= 1'b1;
      tick();
      got = {on_off, change, active_map, busy};
      exp = model_view();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: {on_off,change,map,busy}=%h, want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    dev_on = '0;
    test_reset();
    test_single_join_leave();
    test_round_robin();
    test_cancellation();
    test_rearm_on_grant();
    test_reset_mid_burst();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
